// File: rtl/decryption_pkg.sv
// Shared AES definitions for the decryption core: FSM state encoding, round count,
// Rcon table, forward/inverse S-box, GF(2^8) helpers and the key-schedule step.
// The forward S-box is shared with the encryption path.
package decryption_pkg;

    localparam int unsigned NrAes128 = 10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKeyExp = 3'd1,
        StInit   = 3'd2,
        StRound  = 3'd3,
        StFinal  = 3'd4,
        StDone   = 3'd5
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-128 key-schedule step: next round key from the previous one.
    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        {w0, w1, w2, w3} = prev;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvMixColumns on one column, row 0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/decryption_if.sv
// Handshake bundle for the decryption core: ciphertext/key input channel,
// plaintext output channel and the busy status flag.
interface decryption_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] cipherData;
    logic [127:0] key;
    logic         outValid;
    logic         outReady;
    logic [127:0] outputData;
    logic         busy;

    // Producer/consumer side of the core.
    modport master (
        output inValid, cipherData, key, outReady,
        input  inReady, outValid, outputData, busy
    );

    // The core itself.
    modport slave (
        input  inValid, cipherData, key, outReady,
        output inReady, outValid, outputData, busy
    );
endinterface

// File: rtl/decryption_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module decryption_inv_round
    import decryption_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last_round,
    output logic [127:0] o_state
);

    logic [7:0] w_ark [16];

    // Byte k sits at row k%4, column k/4; row r is rotated right by r columns.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_ark[k] = 8'h00;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[4*c+r] = inv_sbox(i_state[127-8*(4*((c+4-r)%4)+r) -: 8])
                               ^ i_round_key[127-8*(4*c+r) -: 8];
            end
        end
    end

    // Column mixing, bypassed for the final round.
    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++) begin
            if (i_last_round) begin
                o_state[127-32*c -: 32] = {w_ark[4*c], w_ark[4*c+1], w_ark[4*c+2], w_ark[4*c+3]};
            end else begin
                o_state[127-32*c -: 32] =
                    inv_mix_col({w_ark[4*c], w_ark[4*c+1], w_ark[4*c+2], w_ark[4*c+3]});
            end
        end
    end

endmodule

// File: rtl/decryption.sv
// Iterative AES-128 decryption core. Expands the key one round key per cycle,
// then runs one inverse round per cycle; plaintext leaves on a valid/ready channel.
// Optional DECRYPT_KEY_CACHE_EN: skip key expansion when the key repeats.
module decryption
    import decryption_pkg::*;
#(
    parameter int unsigned NR = NrAes128
) (
    input  logic        clk,
    input  logic        rst_n,
    decryption_if.slave bus
);

    if (NR != NrAes128) begin : g_nr_check
        $error("decryption: NR=%0d unsupported, only 10 rounds", NR);
    end

    dec_state_e   r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_state_data;
    logic [127:0] r_rk [NR+1];
    logic         r_in_ready;
    logic         r_busy;
    logic         r_out_valid;
    logic [127:0] r_out_data;

    logic         w_accept;
    logic         w_cache_hit;
    logic [127:0] w_rk_sel;
    logic [127:0] w_rk_prev;
    logic [127:0] w_key_next;
    logic [127:0] w_round_key;
    logic         w_last_round;
    logic [127:0] w_round_out;

    assign w_accept = bus.inValid && r_in_ready;

`ifdef DECRYPT_KEY_CACHE_EN
    logic         r_key_cached;
    logic [127:0] r_last_key;
    assign w_cache_hit = r_key_cached && (bus.key == r_last_key);
`else
    assign w_cache_hit = 1'b0;
`endif

    // Round-key read ports: rk[roundCnt] for rounds, rk[roundCnt-1] for expansion.
    always_comb begin
        w_rk_sel  = r_rk[0];
        w_rk_prev = r_rk[0];
        for (int i = 1; i <= int'(NR); i++) begin
            if (r_cnt == 4'(i)) begin
                w_rk_sel  = r_rk[i];
                w_rk_prev = r_rk[i-1];
            end
        end
    end

    assign w_key_next   = key_step(w_rk_prev, rcon(r_cnt));
    assign w_last_round = (r_state == StFinal);
    assign w_round_key  = w_last_round ? r_rk[0] : w_rk_sel;

    decryption_inv_round u_inv_round (
        .i_state      (r_state_data),
        .i_round_key  (w_round_key),
        .i_last_round (w_last_round),
        .o_state      (w_round_out)
    );

    // Round-key register file; deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_accept) r_rk[0] <= bus.key;
            if (r_state == StKeyExp) begin
                for (int i = 1; i <= int'(NR); i++) begin
                    if (r_cnt == 4'(i)) r_rk[i] <= w_key_next;
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and the working state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef DECRYPT_KEY_CACHE_EN
            r_key_cached <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state_data <= bus.cipherData;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_cnt        <= 4'd1;
                        if (w_cache_hit) begin
                            r_state <= StInit;
                        end else begin
                            r_state <= StKeyExp;
`ifdef DECRYPT_KEY_CACHE_EN
                            // rk[] is about to be overwritten.
                            r_key_cached <= 1'b0;
`endif
                        end
                    end
                end
                StKeyExp: begin
                    if (r_cnt == 4'(NR)) begin
                        r_state <= StInit;
`ifdef DECRYPT_KEY_CACHE_EN
                        r_last_key   <= r_rk[0];
                        r_key_cached <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StInit: begin
                    r_state_data <= r_state_data ^ r_rk[NR];
                    r_cnt        <= 4'(NR - 1);
                    r_state      <= StRound;
                end
                StRound: begin
                    r_state_data <= w_round_out;
                    if (r_cnt == 4'd1) begin
                        r_state <= StFinal;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StFinal: begin
                    r_out_data  <= w_round_out;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (bus.outReady) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.inReady    = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.outValid   = r_out_valid;
    assign bus.outputData = r_out_data;

endmodule

// File: tb/tb_decryption.sv
// Scoreboard bench for the decryption core: FIPS-197 vectors, latency,
// backpressure, mid-operation reset and (when DECRYPT_KEY_CACHE_EN) key caching.
module tb_decryption;

    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int LatFull = 21;
`ifdef DECRYPT_KEY_CACHE_EN
    localparam int LatHit = 11;
`else
    localparam int LatHit = 21;
`endif

    typedef struct {
        logic [127:0] data;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_miss = 0;
    exp_t  sb[$];
    exp_t  cur;
    logic  have_cur = 1'b0;
    logic  prev_valid = 1'b0;
    int    acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decryption_if bus ();

    decryption dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: pop an expectation on every rising outValid; check hold behaviour in DONE.
    always @(negedge clk) begin
        if (bus.outValid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got %h, want no output", bus.outputData);
            end else begin
                cur = sb.pop_front();
                have_cur = 1'b1;
                check({cur.name, "_data"}, bus.outputData, cur.data);
                check({cur.name, "_latency"}, 128'(cyc - cur.acc), 128'(cur.lat));
            end
        end else if (bus.outValid && prev_valid && have_cur) begin
            check("hold_data", bus.outputData, cur.data);
            check("done_inready", 128'(bus.inReady), 128'(0));
        end
        prev_valid = bus.outValid;
    end

    task automatic send(input string name, input logic [127:0] ct, input logic [127:0] k,
                        input logic [127:0] pt, input int lat, input bit expect_out,
                        output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        bus.inValid    = 1'b1;
        bus.cipherData = ct;
        bus.key        = k;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.inReady) ok = 1'b1;
            else @(negedge clk);
        end
        check({name, "_accept"}, 128'(ok), 128'(1));
        if (!ok) begin
            bus.inValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.inValid = 1'b0;
        if (expect_out) sb.push_back('{data: pt, lat: lat, acc: acc_cyc, name: name});
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.outValid && bus.inReady) ok = 1'b1;
        end
        check({name, "_idle"}, 128'(ok), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n          = 1'b0;
        bus.inValid    = 1'b0;
        bus.cipherData = '0;
        bus.key        = '0;
        bus.outReady   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_outvalid", 128'(bus.outValid), 128'(0));
        check("rst_outdata", bus.outputData, 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_inready", 128'(bus.inReady), 128'(1));

        send("c1_first", C1Ct, C1Key, C1Pt, LatFull, 1'b1, acc);
        wait_idle("c1_first");
        send("c1_again", C1Ct, C1Key, C1Pt, LatHit, 1'b1, acc);
        wait_idle("c1_again");
        send("appb", BCt, BKey, BPt, LatFull, 1'b1, acc);
        wait_idle("appb");

        // Backpressure: hold outReady low while a new pair is offered.
        bus.outReady = 1'b0;
        send("bp", C1Ct, C1Key, C1Pt, LatFull, 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.outValid) seen = 1'b1;
        end
        check("bp_outvalid_seen", 128'(seen), 128'(1));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.inValid    = i[0];
            bus.cipherData = BCt;
            bus.key        = BKey;
            check("bp_inready", 128'(bus.inReady), 128'(0));
            check("bp_busy", 128'(bus.busy), 128'(1));
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        wait_idle("bp");
        check("bp_data_kept", bus.outputData, C1Pt);
        repeat (3) @(negedge clk);
        check("bp_post_inready", 128'(bus.inReady), 128'(1));
        check("bp_post_busy", 128'(bus.busy), 128'(0));

        // Reset in the middle of the ROUND phase.
        send("abort", BCt, BKey, BPt, LatFull, 1'b0, acc);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_outvalid", 128'(bus.outValid), 128'(0));
        check("abort_outdata", bus.outputData, 128'(0));
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_inready", 128'(bus.inReady), 128'(1));
        repeat (25) @(negedge clk);
        check("abort_no_output", 128'(bus.outValid), 128'(0));

        // Reset also forgets any cached key.
        send("c1_post_rst", C1Ct, C1Key, C1Pt, LatFull, 1'b1, acc);
        wait_idle("c1_post_rst");
        send("c1_post_rst2", C1Ct, C1Key, C1Pt, LatHit, 1'b1, acc);
        wait_idle("c1_post_rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
